// File: rtl/spi_flash_rd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_flash_rd_ctrl
// SPI mode-0 master that fetches one 32-bit word per request from an N25Q
// serial flash using the single-bit READ (0x03) command on chip select 0.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  read request valid
//   req_ready  high only while idle; request taken on req_valid & req_ready
//   req_addr   24-bit flash byte address, used as given
//   rsp_valid  response word valid, held until rsp_ready
//   rsp_ready  response consumer ready
//   rsp_data   read word, first flash byte in [7:0], fourth in [31:24]
//   busy       high whenever not idle
//   spi_cs     active-low selects, [0] = flash, [1] always high
//   spi_clk    SCK, idles low
//   spi_mosi   serial data to flash, MSB first
//   spi_miso   serial data from flash
// -----------------------------------------------------------------------------
module spi_flash_rd_ctrl #(
   parameter int CLK_DIV = 2,  // SCK half-period in clk cycles (>= 1)
   parameter int CS_GAP  = 2   // minimum clk cycles of deselect between reads (>= 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic [1:0]  spi_cs,
   output logic        spi_clk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
   localparam logic [7:0]       CMD_READ = 8'h03;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_RESP,
      S_GAP
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [5:0]       bit_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             cs_n;
   logic [31:0]      tx_sr;
   logic [31:0]      rx_sr;
   logic             shifting;
   logic             half_done;
   logic             rise_edge;
   logic             fall_edge;
   logic             accept;

   // Bytes arrive MSB-first with the first byte in the top of rx_sr; the
   // response wants the first byte in the least-significant position.
   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   assign spi_cs    = {1'b1, cs_n};
   assign shifting  = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
   assign half_done = (div_cnt == DIV_LAST);
   // spi_clk is the current SCK phase, so a finished half-period while low is
   // the rising edge and while high is the falling edge.
   assign rise_edge = shifting && half_done && !spi_clk;
   assign fall_edge = shifting && half_done && spi_clk;
   assign accept    = (state == S_IDLE) && req_valid;

   // Shift registers carry no reset: they are always reloaded or fully
   // refilled before their contents are used.
   always_ff @(posedge clk) begin
      if (accept) begin
         // Bit 31 of {cmd, addr} goes straight onto spi_mosi at acceptance,
         // so only the remaining 31 bits are kept here.
         tx_sr <= {CMD_READ[6:0], req_addr, 1'b0};
      end else if (fall_edge) begin
         tx_sr <= {tx_sr[30:0], 1'b0};
      end
      if (rise_edge && (state == S_DATA)) begin
         rx_sr <= {rx_sr[30:0], spi_miso};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cs_n      <= 1'b1;
         spi_clk   <= 1'b0;
         spi_mosi  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  state     <= S_CMD;
                  cs_n      <= 1'b0;
                  spi_clk   <= 1'b0;
                  spi_mosi  <= CMD_READ[7];
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
               end
            end
            S_CMD, S_ADDR, S_DATA: begin
               if (!half_done) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (!spi_clk) begin
                     spi_clk <= 1'b1;
                  end else begin
                     spi_clk <= 1'b0;
                     bit_cnt <= bit_cnt + 6'd1;
                     // Once the last address bit has been clocked out the
                     // line is held low for the whole data phase.
                     spi_mosi <= ((bit_cnt == 6'd31) || (state == S_DATA)) ? 1'b0 : tx_sr[31];
                     if ((state == S_CMD) && (bit_cnt == 6'd7)) begin
                        state <= S_ADDR;
                     end else if ((state == S_ADDR) && (bit_cnt == 6'd31)) begin
                        state <= S_DATA;
                     end else if ((state == S_DATA) && (bit_cnt == 6'd63)) begin
                        state     <= S_RESP;
                        bit_cnt   <= '0;
                        cs_n      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= byte_swap(rx_sr);
                     end
                  end
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  gap_cnt   <= '0;
                  state     <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_rd_ctrl
// Bench for spi_flash_rd_ctrl. Two instances share clk/rst_n: index 0 uses
// CLK_DIV=2/CS_GAP=2, index 1 uses CLK_DIV=1/CS_GAP=1. Each has a behavioural
// mode-0 flash that records the command/address stream and returns bytes
// from a shared memory image.
// -----------------------------------------------------------------------------
module tb_spi_flash_rd_ctrl;

   localparam int D0 = 2;
   localparam int G0 = 2;
   localparam int D1 = 1;
   localparam int G1 = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        req_valid;
   logic [1:0]        rsp_ready;
   logic [1:0][23:0]  req_addr;
   logic [1:0]        req_ready;
   logic [1:0]        rsp_valid;
   logic [1:0]        busy;
   logic [1:0]        spi_clk;
   logic [1:0]        spi_mosi;
   logic [1:0][31:0]  rsp_data;
   logic [1:0][1:0]   spi_cs;

   logic [7:0] mem [1024];
   int tests = 0;
   int fails = 0;

   function automatic logic [7:0] mem_at(input logic [23:0] a);
      return mem[a[9:0]];
   endfunction

   // Expected word: four consecutive flash bytes, first byte least significant.
   function automatic logic [31:0] model_word(input logic [23:0] a);
      return {mem_at(a + 24'd3), mem_at(a + 24'd2), mem_at(a + 24'd1), mem_at(a)};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int D = (g == 0) ? D0 : D1;
      localparam int G = (g == 0) ? G0 : G1;
      logic        miso = 1'b0;
      int          rxcnt = 0;
      int          sck_total = 0;
      time         last_rise = 0;
      time         sck_per = 0;
      logic [31:0] cmdaddr = '0;
      logic [7:0]  cur_byte;

      spi_flash_rd_ctrl #(.CLK_DIV(D), .CS_GAP(G)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_addr  (req_addr[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_data  (rsp_data[g]),
         .busy      (busy[g]),
         .spi_cs    (spi_cs[g]),
         .spi_clk   (spi_clk[g]),
         .spi_mosi  (spi_mosi[g]),
         .spi_miso  (miso)
      );

      // Flash side: sample MOSI on SCK rise, count edges, restart on select.
      always @(posedge spi_clk[g] or negedge spi_cs[g][0]) begin
         if (spi_clk[g]) begin
            sck_total++;
            sck_per   = $time - last_rise;
            last_rise = $time;
            if (!spi_cs[g][0]) begin
               if (rxcnt < 32) cmdaddr = {cmdaddr[30:0], spi_mosi[g]};
               rxcnt++;
            end
         end else begin
            rxcnt = 0;
         end
      end

      // Flash drives data bits after the SCK fall, MSB first per byte.
      always @(negedge spi_clk[g]) begin
         if (!spi_cs[g][0] && rxcnt >= 32 && rxcnt < 64) begin
            cur_byte = mem_at(cmdaddr[23:0] + 24'((rxcnt - 32) / 8));
            miso     = cur_byte[3'(7 - ((rxcnt - 32) % 8))];
         end
      end
   end

   function automatic int rises(input int s);
      return (s == 0) ? g_dut[0].rxcnt : g_dut[1].rxcnt;
   endfunction
   function automatic int sck_tot(input int s);
      return (s == 0) ? g_dut[0].sck_total : g_dut[1].sck_total;
   endfunction
   function automatic time sck_period(input int s);
      return (s == 0) ? g_dut[0].sck_per : g_dut[1].sck_per;
   endfunction
   function automatic logic [31:0] cmdaddr_of(input int s);
      return (s == 0) ? g_dut[0].cmdaddr : g_dut[1].cmdaddr;
   endfunction
   function automatic int div_of(input int s);
      return (s == 0) ? D0 : D1;
   endfunction
   function automatic int gap_of(input int s);
      return (s == 0) ? G0 : G1;
   endfunction

   // One complete read with optional response backpressure.
   task automatic do_read(input int s, input logic [23:0] a, input int bp, input string nm);
      int          w;
      int          k;
      int          n;
      int          sck0;
      bit          ok;
      logic [31:0] exp;
      exp          = model_word(a);
      rsp_ready[s] = 1'b0;
      req_addr[s]  = a;
      req_valid[s] = 1'b1;
      w = 0;
      while (req_ready[s] !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (w >= 100) begin
         fails++;
         $display("FAIL %s_accept: req_ready=%b, expected 1 within 100 cycles", nm, req_ready[s]);
         req_valid[s] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[s] = 1'b0;
      req_addr[s]  = 24'($urandom);
      tests++;
      if (spi_cs[s] !== 2'b10 || spi_clk[s] !== 1'b0 || spi_mosi[s] !== 1'b0 ||
          busy[s] !== 1'b1 || req_ready[s] !== 1'b0) begin
         fails++;
         $display("FAIL %s_start: cs=%b sck=%b mosi=%b busy=%b rdy=%b, expected 10 0 0 1 0",
                  nm, spi_cs[s], spi_clk[s], spi_mosi[s], busy[s], req_ready[s]);
      end
      if (bp == 0) rsp_ready[s] = 1'b1;
      k = 1;
      while (rsp_valid[s] !== 1'b1 && k < 700) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (k != 1 + 128 * div_of(s)) begin
         fails++;
         $display("FAIL %s_latency: rsp_valid at T+%0d, expected T+%0d", nm, k, 1 + 128 * div_of(s));
      end
      tests++;
      if (rsp_data[s] !== exp) begin
         fails++;
         $display("FAIL %s_data: got %h, expected %h", nm, rsp_data[s], exp);
      end
      tests++;
      if (cmdaddr_of(s) !== {8'h03, a}) begin
         fails++;
         $display("FAIL %s_mosi: flash saw %h, expected %h", nm, cmdaddr_of(s), {8'h03, a});
      end
      tests++;
      if (rises(s) != 64 || sck_period(s) != time'(20 * div_of(s)) ||
          spi_cs[s] !== 2'b11 || spi_clk[s] !== 1'b0) begin
         fails++;
         $display("FAIL %s_sck: rises=%0d period=%0t cs=%b sck=%b, expected 64 %0d 11 0",
                  nm, rises(s), sck_period(s), spi_cs[s], spi_clk[s], 20 * div_of(s));
      end
      if (bp > 0) begin
         ok   = 1'b1;
         sck0 = sck_tot(s);
         for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (rsp_valid[s] !== 1'b1 || rsp_data[s] !== exp || req_ready[s] !== 1'b0 ||
                spi_cs[s] !== 2'b11 || busy[s] !== 1'b1 || sck_tot(s) != sck0) ok = 1'b0;
         end
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL %s_backpressure: vld=%b data=%h rdy=%b cs=%b edges=%0d, expected 1 %h 0 11 %0d",
                     nm, rsp_valid[s], rsp_data[s], req_ready[s], spi_cs[s], sck_tot(s), exp, sck0);
         end
         rsp_ready[s] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      rsp_ready[s] = 1'b0;
      tests++;
      if (rsp_valid[s] !== 1'b0) begin
         fails++;
         $display("FAIL %s_rsp_drop: rsp_valid=%b, expected 0", nm, rsp_valid[s]);
      end
      n  = 1;
      ok = 1'b1;
      while (req_ready[s] !== 1'b1 && n < 50) begin
         if (spi_cs[s] !== 2'b11 || busy[s] !== 1'b1) ok = 1'b0;
         @(negedge clk);
         n++;
      end
      tests++;
      if (n != gap_of(s) + 1 || !ok || busy[s] !== 1'b0) begin
         fails++;
         $display("FAIL %s_gap: idle after %0d cycles ok=%b busy=%b, expected %0d 1 0",
                  nm, n, ok, busy[s], gap_of(s) + 1);
      end
   endtask

   // Assert reset once the flash has seen `at` SCK rises of a fresh read.
   task automatic reset_mid(input int s, input int at, input string nm);
      int w;
      bit ok;
      req_addr[s]  = 24'($urandom);
      req_valid[s] = 1'b1;
      w = 0;
      while (req_ready[s] !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[s] = 1'b0;
      w = 0;
      while (rises(s) < at && w < 1000) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (rises(s) != at) begin
         fails++;
         $display("FAIL %s_reach: rises=%0d, expected %0d", nm, rises(s), at);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (spi_cs[s] !== 2'b11 || spi_clk[s] !== 1'b0 || spi_mosi[s] !== 1'b0 || rsp_valid[s] !== 1'b0 ||
          rsp_data[s] !== 32'h0 || busy[s] !== 1'b0 || req_ready[s] !== 1'b1) begin
         fails++;
         $display("FAIL %s_async: cs=%b sck=%b mosi=%b vld=%b data=%h busy=%b rdy=%b, expected 11 0 0 0 0 0 1",
                  nm, spi_cs[s], spi_clk[s], spi_mosi[s], rsp_valid[s], rsp_data[s], busy[s], req_ready[s]);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rsp_valid[s] !== 1'b0 || spi_cs[s] !== 2'b11 || busy[s] !== 1'b0) ok = 1'b0;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_quiet: vld=%b cs=%b busy=%b after reset, expected 0 11 0",
                  nm, rsp_valid[s], spi_cs[s], busy[s]);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         tests++;
         if (spi_cs[s] !== 2'b11 || spi_clk[s] !== 1'b0 || spi_mosi[s] !== 1'b0 || rsp_valid[s] !== 1'b0 ||
             rsp_data[s] !== 32'h0 || busy[s] !== 1'b0 || req_ready[s] !== 1'b1) begin
            fails++;
            $display("FAIL reset_%0d: cs=%b sck=%b mosi=%b vld=%b data=%h busy=%b rdy=%b, expected 11 0 0 0 0 0 1",
                     s, spi_cs[s], spi_clk[s], spi_mosi[s], rsp_valid[s], rsp_data[s], busy[s], req_ready[s]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      do_read(0, 24'($urandom), 0, "pre_reset");
      reset_mid(0, 45, "reset_data");
   endtask

   task automatic test_single_read();
      do_read(0, 24'h000100, 0, "single");
   endtask

   task automatic test_backpressure();
      do_read(0, 24'($urandom), 10, "bp10");
   endtask

   task automatic test_back_to_back();
      int k;
      int n;
      int cs_hi;
      int w;
      rsp_ready[0] = 1'b1;
      req_addr[0]  = 24'h000000;
      req_valid[0] = 1'b1;
      w = 0;
      while (req_ready[0] !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      @(negedge clk);
      req_addr[0] = 24'h000004;
      k = 1;
      while (rsp_valid[0] !== 1'b1 && k < 700) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (rsp_data[0] !== model_word(24'h000000) || cmdaddr_of(0) !== 32'h03000000 || k != 1 + 128 * D0) begin
         fails++;
         $display("FAIL b2b_first: data=%h addr=%h lat=%0d, expected %h 03000000 %0d",
                  rsp_data[0], cmdaddr_of(0), k, model_word(24'h000000), 1 + 128 * D0);
      end
      cs_hi = 1;
      n     = 0;
      @(posedge clk);
      do begin
         @(negedge clk);
         n++;
         if (spi_cs[0][0] === 1'b1) cs_hi++;
      end while (req_ready[0] !== 1'b1 && n < 50);
      tests++;
      if (n != G0 + 1) begin
         fails++;
         $display("FAIL b2b_accept: second accept %0d cycles after handshake, expected %0d", n, G0 + 1);
      end
      tests++;
      if (cs_hi < G0) begin
         fails++;
         $display("FAIL b2b_cs_gap: cs high %0d cycles, expected at least %0d", cs_hi, G0);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      tests++;
      if (spi_cs[0] !== 2'b10 || busy[0] !== 1'b1) begin
         fails++;
         $display("FAIL b2b_restart: cs=%b busy=%b, expected 10 1", spi_cs[0], busy[0]);
      end
      k = 1;
      while (rsp_valid[0] !== 1'b1 && k < 700) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (rsp_data[0] !== model_word(24'h000004) || cmdaddr_of(0) !== 32'h03000004) begin
         fails++;
         $display("FAIL b2b_second: data=%h addr=%h, expected %h 03000004",
                  rsp_data[0], cmdaddr_of(0), model_word(24'h000004));
      end
      @(posedge clk);
      @(negedge clk);
      rsp_ready[0] = 1'b0;
      w = 0;
      while (req_ready[0] !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      repeat (5) @(negedge clk);
      tests++;
      if (busy[0] !== 1'b0 || spi_cs[0] !== 2'b11) begin
         fails++;
         $display("FAIL b2b_idle: busy=%b cs=%b, expected 0 11", busy[0], spi_cs[0]);
      end
   endtask

   task automatic test_reset_mid_addr();
      reset_mid(0, 20, "reset_addr");
      do_read(0, 24'($urandom), 0, "after_reset");
   endtask

   task automatic test_clkdiv1();
      do_read(1, 24'h0000FC, 0, "div1");
      do_read(1, 24'($urandom), 3, "div1_bp");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) do_read(0, 24'($urandom), int'($urandom_range(0, 4)), "rand0");
      for (int i = 0; i < 4; i++) do_read(1, 24'($urandom), int'($urandom_range(0, 4)), "rand1");
   endtask

   initial begin
      req_valid = '0;
      rsp_ready = '0;
      req_addr  = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem[10'h100] = 8'h11;
      mem[10'h101] = 8'h22;
      mem[10'h102] = 8'h33;
      mem[10'h103] = 8'h44;
      test_reset();
      test_single_read();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_addr();
      test_clkdiv1();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "timeout");
   end

endmodule
